// File: rtl/rename_stage.sv
// rtl/rename_stage.sv - register rename stage: RAT lookup, free-list allocation, ROB index, registered output
module rename_stage #(
  parameter int NUM_ARCH_REGS     = 32,
  parameter int NUM_PHYSICAL_REGS = 64,
  parameter int FREE_LIST_DEPTH   = 32,
  parameter int ROB_ENTRIES       = 64,
  localparam int AW = $clog2(NUM_ARCH_REGS),
  localparam int PW = $clog2(NUM_PHYSICAL_REGS),
  localparam int RW = $clog2(ROB_ENTRIES),
  localparam int CW = $clog2(FREE_LIST_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] arch_rd,
  input  logic [AW-1:0] arch_rs1,
  input  logic [AW-1:0] arch_rs2,
  input  logic          has_rd,
  input  logic [6:0]    opcode,
  input  logic [31:0]   immediate,
  input  logic          rob_full,
  input  logic          retire_valid,
  input  logic [PW-1:0] retire_phys,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] phys_dest,
  output logic [PW-1:0] phys_rs1,
  output logic [PW-1:0] phys_rs2,
  output logic [PW-1:0] old_phys_dest,
  output logic [6:0]    opcode_out,
  output logic [31:0]   immediate_out,
  output logic [RW-1:0] rob_index,
  output logic [CW-1:0] free_count
);

  localparam int FW = $clog2(FREE_LIST_DEPTH);

  // Register alias table and circular free list
  logic [PW-1:0] rat_q [NUM_ARCH_REGS];
  logic [PW-1:0] fl_q  [FREE_LIST_DEPTH];
  logic [FW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] rob_q;

  // Output holding register
  logic          out_valid_q;
  logic [PW-1:0] dest_q, rs1_q, rs2_q, old_q;
  logic [6:0]    op_q;
  logic [31:0]   imm_q;
  logic [RW-1:0] robi_q;

  logic accept, alloc, retire_push;
  logic [PW-1:0] head_val;

  // Conservative: stall whenever the free list is empty, even for non-writers
  assign in_ready    = !reset && !rob_full && (count_q != '0) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign alloc       = accept && has_rd && (arch_rd != '0);
  assign retire_push = retire_valid && (retire_phys != '0) && (count_q < CW'(FREE_LIST_DEPTH));
  assign head_val    = fl_q[head_q];

  // Occupancy: simultaneous pop and push cancel out
  always_comb begin
    count_d = count_q;
    case ({alloc, retire_push})
      2'b10:   count_d = count_q - CW'(1);
      2'b01:   count_d = count_q + CW'(1);
      default: count_d = count_q;
    endcase
  end

  // RAT: identity on reset; writer's rd remapped to the popped free register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) rat_q[i] <= PW'(i);
    end else if (alloc) begin
      rat_q[arch_rd] <= head_val;
    end
  end

  // Free list: pop at head on alloc, push retired register at tail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FREE_LIST_DEPTH; i++) fl_q[i] <= PW'(NUM_ARCH_REGS + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CW'(FREE_LIST_DEPTH);
    end else begin
      if (alloc) head_q <= head_q + FW'(1);
      if (retire_push) begin
        fl_q[tail_q] <= retire_phys;
        tail_q       <= tail_q + FW'(1);
      end
      count_q <= count_d;
    end
  end

  // Round-robin ROB allocation counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rob_q <= '0;
    else if (accept) rob_q <= rob_q + RW'(1);
  end

  // Output register: load on accept, drop after handoff, hold while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      dest_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      old_q       <= '0;
      op_q        <= '0;
      imm_q       <= '0;
      robi_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      dest_q      <= alloc ? head_val : '0;
      old_q       <= alloc ? rat_q[arch_rd] : '0;
      rs1_q       <= rat_q[arch_rs1];
      rs2_q       <= rat_q[arch_rs2];
      op_q        <= opcode;
      imm_q       <= immediate;
      robi_q      <= rob_q;
    end else if (out_ready && out_valid_q) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid     = out_valid_q;
  assign phys_dest     = dest_q;
  assign phys_rs1      = rs1_q;
  assign phys_rs2      = rs2_q;
  assign old_phys_dest = old_q;
  assign opcode_out    = op_q;
  assign immediate_out = imm_q;
  assign rob_index     = robi_q;
  assign free_count    = count_q;

endmodule

// File: tb/tb_rename_stage.sv
// tb/tb_rename_stage.sv - self-checking bench for rename_stage with queue-based reference model
module tb_rename_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  arch_rd, arch_rs1, arch_rs2;
  logic        has_rd;
  logic [6:0]  opcode;
  logic [31:0] immediate;
  logic        rob_full;
  logic        retire_valid;
  logic [5:0]  retire_phys;
  logic        out_valid, out_ready;
  logic [5:0]  phys_dest, phys_rs1, phys_rs2, old_phys_dest;
  logic [6:0]  opcode_out;
  logic [31:0] immediate_out;
  logic [5:0]  rob_index;
  logic [5:0]  free_count;

  int tests = 0;
  int fails = 0;
  int seq   = 0;

  rename_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .arch_rd(arch_rd), .arch_rs1(arch_rs1), .arch_rs2(arch_rs2), .has_rd(has_rd),
    .opcode(opcode), .immediate(immediate), .rob_full(rob_full),
    .retire_valid(retire_valid), .retire_phys(retire_phys),
    .out_valid(out_valid), .out_ready(out_ready),
    .phys_dest(phys_dest), .phys_rs1(phys_rs1), .phys_rs2(phys_rs2),
    .old_phys_dest(old_phys_dest), .opcode_out(opcode_out),
    .immediate_out(immediate_out), .rob_index(rob_index), .free_count(free_count)
  );

  always #5 clk = ~clk;

  // Reference model: mapping table, free list as a plain FIFO queue
  int rat [32];
  int fl [$];
  int m_rob;
  bit m_valid;
  int m_dest, m_rs1, m_rs2, m_old, m_robi;
  logic [6:0]  m_op;
  logic [31:0] m_imm;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rat[i] = i;
    fl.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
    m_rob = 0; m_valid = 0;
    m_dest = 0; m_rs1 = 0; m_rs2 = 0; m_old = 0; m_robi = 0; m_op = 0; m_imm = 0;
  endtask

  function automatic bit m_ready();
    return !reset && !rob_full && (fl.size() != 0) && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
    end else begin
      bit acc, al, ret;
      acc = in_valid && m_ready();
      al  = acc && has_rd && (arch_rd != 0);
      ret = retire_valid && (retire_phys != 0) && (fl.size() < 32);
      if (acc) begin
        m_valid = 1;
        m_rs1 = rat[arch_rs1];
        m_rs2 = rat[arch_rs2];
        m_op = opcode; m_imm = immediate; m_robi = m_rob;
        m_rob = (m_rob + 1) % 64;
        m_dest = al ? fl[0] : 0;
        m_old  = al ? rat[arch_rd] : 0;
      end else if (out_ready) begin
        m_valid = 0;
      end
      if (al) begin
        rat[arch_rd] = fl[0];
        void'(fl.pop_front());
      end
      if (ret) fl.push_back(int'(retire_phys));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("free_count", 32'(free_count), fl.size());
    if (m_valid && out_valid) begin
      chk("m.phys_dest", 32'(phys_dest), m_dest);
      chk("m.phys_rs1", 32'(phys_rs1), m_rs1);
      chk("m.phys_rs2", 32'(phys_rs2), m_rs2);
      chk("m.old_phys_dest", 32'(old_phys_dest), m_old);
      chk("m.rob_index", 32'(rob_index), m_robi);
      chk("m.opcode_out", 32'(opcode_out), 32'(m_op));
      chk("m.immediate_out", immediate_out, m_imm);
    end
  end

  task automatic set_in(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic hrd, input logic rv, input logic [5:0] rp);
    in_valid = v; arch_rd = rd; arch_rs1 = rs1; arch_rs2 = rs2; has_rd = hrd;
    retire_valid = rv; retire_phys = rp;
    seq++;
    opcode = 7'(seq); immediate = $urandom;
  endtask

  task automatic step(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic hrd, input logic rv, input logic [5:0] rp);
    set_in(v, rd, rs1, rs2, hrd, rv, rp);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] held_dest;

  initial begin
    reset = 1'b1; out_ready = 1'b1; rob_full = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.free_count", 32'(free_count), 32);
    chk("rst.rob_index", 32'(rob_index), 0);

    // add x5,x1,x2
    step(1, 5, 1, 2, 1, 0, 0);
    chk("add.dest", 32'(phys_dest), 32);
    chk("add.rs1", 32'(phys_rs1), 1);
    chk("add.rs2", 32'(phys_rs2), 2);
    chk("add.old", 32'(old_phys_dest), 5);
    chk("add.rob", 32'(rob_index), 0);
    chk("add.fc", 32'(free_count), 31);
    // two more writes to x5, then a read of x5
    step(1, 5, 5, 0, 1, 0, 0);
    chk("w2.dest", 32'(phys_dest), 33);
    chk("w2.old", 32'(old_phys_dest), 32);
    chk("w2.rs1", 32'(phys_rs1), 32);
    chk("w2.rob", 32'(rob_index), 1);
    step(1, 5, 0, 0, 1, 0, 0);
    chk("w3.dest", 32'(phys_dest), 34);
    chk("w3.old", 32'(old_phys_dest), 33);
    chk("w3.rob", 32'(rob_index), 2);
    step(1, 0, 5, 0, 0, 0, 0);
    chk("rd.rs1", 32'(phys_rs1), 34);
    chk("rd.dest", 32'(phys_dest), 0);
    chk("rd.old", 32'(old_phys_dest), 0);
    chk("rd.rob", 32'(rob_index), 3);
    chk("rd.fc", 32'(free_count), 29);
    // rd == rs1 sees the pre-update mapping
    step(1, 3, 3, 0, 1, 0, 0);
    chk("self.rs1", 32'(phys_rs1), 3);
    chk("self.dest", 32'(phys_dest), 35);
    // x0 destination allocates nothing
    step(1, 0, 1, 0, 1, 0, 0);
    chk("x0.dest", 32'(phys_dest), 0);
    chk("x0.fc", 32'(free_count), 28);

    // fresh state: retire into a full list is ignored
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    step(0, 0, 0, 0, 0, 1, 9);
    chk("retire_full.fc", 32'(free_count), 32);

    // drain the free list completely
    for (int i = 0; i < 32; i++) step(1, 5'(1 + (i % 31)), 0, 0, 1, 0, 0);
    chk("drain.last_dest", 32'(phys_dest), 63);
    chk("drain.fc", 32'(free_count), 0);
    set_in(1, 2, 0, 0, 1, 0, 0);
    #1 chk("empty.in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("empty.fc", 32'(free_count), 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("retire0.fc", 32'(free_count), 0);
    step(0, 0, 0, 0, 0, 1, 5);
    chk("retire5.fc", 32'(free_count), 1);
    step(1, 7, 0, 0, 1, 0, 0);
    chk("reuse.dest", 32'(phys_dest), 5);
    chk("reuse.fc", 32'(free_count), 0);
    step(0, 0, 0, 0, 0, 1, 10);
    step(0, 0, 0, 0, 0, 1, 11);
    chk("refill.fc", 32'(free_count), 2);

    // back-pressure from the issue queue
    out_ready = 1'b0;
    step(1, 8, 7, 0, 1, 0, 0);
    chk("bp.dest", 32'(phys_dest), 10);
    chk("bp.rs1", 32'(phys_rs1), 5);
    held_dest = phys_dest;
    set_in(1, 9, 0, 0, 1, 0, 0);
    #1 chk("bp.in_ready", 32'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp.stable_dest", 32'(phys_dest), 32'(held_dest));
    chk("bp.valid", 32'(out_valid), 1);
    chk("bp.fc", 32'(free_count), 1);

    // ROB full blocks acceptance
    out_ready = 1'b1; rob_full = 1'b1;
    #1 chk("robfull.in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("robfull.valid", 32'(out_valid), 0);
    chk("robfull.fc", 32'(free_count), 1);
    rob_full = 1'b0;

    // alloc and retire together keep occupancy
    step(1, 9, 0, 0, 1, 1, 12);
    chk("both.dest", 32'(phys_dest), 11);
    chk("both.fc", 32'(free_count), 1);

    // reset while an instruction is held
    step(1, 4, 0, 0, 1, 0, 0);
    chk("pre_rst.valid", 32'(out_valid), 1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("midrst.valid", 32'(out_valid), 0);
    chk("midrst.fc", 32'(free_count), 32);
    chk("midrst.rob", 32'(rob_index), 0);
    chk("midrst.dest", 32'(phys_dest), 0);
    chk("midrst.in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 reset = 1'b0;
    step(1, 7, 7, 0, 1, 0, 0);
    chk("post.dest", 32'(phys_dest), 32);
    chk("post.rs1", 32'(phys_rs1), 7);
    chk("post.rob", 32'(rob_index), 0);
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
